interp_cmd_scheduler: RTL and testbench

//  Sequences commands into the interpolation FSM, which accepts one init/update/alert/start at a time.

---
 rtl/interp_sched_pkg.sv | 23 ++
 rtl/interp_sched_fifo.sv | 56 +++++
 rtl/interp_cmd_scheduler.sv | 154 +++++++++++++++
 tb/tb_interp_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_sched_pkg.sv
// Shared opcode encodings, FSM state values and the pulse-decode helper for
// the interpolation command scheduler.
package interp_sched_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INIT   = 2'd0,
    OP_UPDATE = 2'd1,
    OP_START  = 2'd2,
    OP_ALERT  = 2'd3
  } op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // One-hot pulse vector indexed by opcode: [0]=init [1]=update [2]=start [3]=alert.
  function automatic logic [3:0] op_onehot(input op_e op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/interp_sched_fifo.sv
// Synchronous show-ahead FIFO of {op,data} entries with occupancy, full and
// empty. A push while full is accepted when a pop happens in the same cycle.
module interp_sched_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 18,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/interp_cmd_scheduler.sv
// Issues queued solver commands and priority alerts to the interpolation FSM,
// one transaction at a time. Define INTERP_SCHED_WDOG_EN to add the WAIT watchdog.
module interp_cmd_scheduler
  import interp_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16,
  parameter int WDOG_CYC   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [1:0]                  req_op,
  input  logic [DATA_W-1:0]           req_data,
  output logic                        req_ready,
  input  logic                        alert_req,
  input  logic [DATA_W-1:0]           alert_data,
  output logic                        alert_ack,
  output logic                        fsm_init,
  output logic                        fsm_update,
  output logic                        fsm_alert,
  output logic                        fsm_start,
  input  logic                        fsm_done,
  output logic [DATA_W-1:0]           cmd_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] queue_level,
  output logic                        timeout_err
);

  localparam int ENTRY_W = OP_W + DATA_W;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [ENTRY_W-1:0] head;
  op_e                head_op;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop_now;
  logic               take_alert;
  logic               issue_go;
  op_e                issue_op;
  logic [DATA_W-1:0]  issue_data;
  logic               wdog_fire;
  logic [3:0]         pulse_q;

  assign push = req_valid & req_ready;

  interp_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_now),
    .wdata ({req_op, req_data}),
    .rdata (head),
    .level (queue_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op   = op_e'(head[ENTRY_W-1 -: OP_W]);
  assign head_data = head[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational;
    // a missing assignment would infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue_go) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (fsm_done || wdog_fire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Alert arbitration: a held alert request always wins over the queue head.
  always_comb begin
    take_alert = 1'b0;
    pop_now    = 1'b0;
    issue_op   = head_op;
    issue_data = head_data;
    if (state == ST_IDLE) begin
      if (alert_req) begin
        take_alert = 1'b1;
        issue_op   = OP_ALERT;
        issue_data = alert_data;
      end else if (!fifo_empty) begin
        pop_now = 1'b1;
      end
    end
  end

  assign issue_go = take_alert | pop_now;

  // Pulses and payload are registered on the edge that enters ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q   <= '0;
      alert_ack <= 1'b0;
      cmd_data  <= '0;
    end else begin
      pulse_q   <= issue_go ? op_onehot(issue_op) : 4'b0000;
      alert_ack <= take_alert;
      if (issue_go) cmd_data <= issue_data;
    end
  end

  assign fsm_init   = pulse_q[OP_INIT];
  assign fsm_update = pulse_q[OP_UPDATE];
  assign fsm_start  = pulse_q[OP_START];
  assign fsm_alert  = pulse_q[OP_ALERT];

`ifdef INTERP_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;

  // Counter is held at zero outside WAIT, so it starts fresh on every entry.
  assign wdog_fire = (state == ST_WAIT) && !fsm_done &&
                     (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != ST_WAIT) wdog_cnt <= '0;
      else                  wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wdog_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full queue still accepts a push
  // while the scheduler drains it; this never depends on req_valid.
  assign req_ready = ~fifo_full | pop_now;
  assign busy      = (state != ST_IDLE) | ~fifo_empty | alert_req;

endmodule

// File: tb/tb_interp_cmd_scheduler.sv
// Randomized and directed bench for interp_cmd_scheduler against a
// transaction-level model built from a command queue and an in-flight slot.
module tb_interp_cmd_scheduler;
  import interp_sched_pkg::*;

  localparam int D  = 4;
  localparam int W  = 16;
  localparam int WD = 16;
  localparam int LW = $clog2(D) + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
  } cmd_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [W-1:0]  req_data;
  logic          req_ready;
  logic          alert_req;
  logic [W-1:0]  alert_data;
  logic          alert_ack;
  logic          fsm_init;
  logic          fsm_update;
  logic          fsm_alert;
  logic          fsm_start;
  logic          fsm_done;
  logic [W-1:0]  cmd_data;
  logic          busy;
  logic [LW-1:0] queue_level;
  logic          timeout_err;

  interp_cmd_scheduler #(
    .FIFO_DEPTH (D),
    .DATA_W     (W),
    .WDOG_CYC   (WD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .alert_req   (alert_req),
    .alert_data  (alert_data),
    .alert_ack   (alert_ack),
    .fsm_init    (fsm_init),
    .fsm_update  (fsm_update),
    .fsm_alert   (fsm_alert),
    .fsm_start   (fsm_start),
    .fsm_done    (fsm_done),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .queue_level (queue_level),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending commands, whether the scheduler is free, and the
  // command currently handed to the FSM.
  cmd_t         q[$];
  bit           m_free;
  bit           m_pulse;
  bit           m_waiting;
  bit           m_is_alert;
  logic [1:0]   m_op;
  logic [W-1:0] m_cmd;
  bit           m_tout;
  int           m_wait_cyc;
  bit           ack_prev;

  task automatic model_reset();
    q.delete();
    m_free     = 1'b1;
    m_pulse    = 1'b0;
    m_waiting  = 1'b0;
    m_is_alert = 1'b0;
    m_op       = 2'd0;
    m_cmd      = '0;
    m_tout     = 1'b0;
    m_wait_cyc = 0;
    ack_prev   = 1'b0;
  endtask

  function automatic bit exp_ready();
    return (q.size() < D) || (m_free && !alert_req && q.size() != 0);
  endfunction

  task automatic check_outputs();
    check("req_ready",   req_ready,   exp_ready());
    check("busy",        busy,        !m_free || q.size() != 0 || alert_req);
    check("queue_level", queue_level, q.size());
    check("fsm_init",    fsm_init,    m_pulse && m_op == OP_INIT);
    check("fsm_update",  fsm_update,  m_pulse && m_op == OP_UPDATE);
    check("fsm_start",   fsm_start,   m_pulse && m_op == OP_START);
    check("fsm_alert",   fsm_alert,   m_pulse && m_op == OP_ALERT);
    check("alert_ack",   alert_ack,   m_pulse && m_is_alert);
    check("cmd_data",    cmd_data,    m_cmd);
    check("timeout_err", timeout_err, m_tout);
  endtask

  task automatic model_edge();
    bit   accept;
    cmd_t c;
    accept = req_valid && exp_ready();
    if (m_free) begin
      if (alert_req) begin
        m_op = OP_ALERT; m_cmd = alert_data; m_is_alert = 1'b1;
        m_pulse = 1'b1; m_free = 1'b0;
      end else if (q.size() != 0) begin
        c = q.pop_front();
        m_op = c.op; m_cmd = c.data; m_is_alert = 1'b0;
        m_pulse = 1'b1; m_free = 1'b0;
      end
    end else if (m_pulse) begin
      m_pulse = 1'b0; m_waiting = 1'b1; m_wait_cyc = 0;
    end else if (m_waiting) begin
      if (fsm_done) begin
        m_waiting = 1'b0; m_free = 1'b1;
      end
`ifdef INTERP_SCHED_WDOG_EN
      else if (m_wait_cyc == WD - 1) begin
        m_tout = 1'b1; m_waiting = 1'b0; m_free = 1'b1;
      end else begin
        m_wait_cyc++;
      end
`endif
    end
    if (accept) q.push_back('{op: req_op, data: req_data});
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                      input bit raise, input logic [W-1:0] ad, input bit done);
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_data  = d;
    fsm_done  = done;
    if (ack_prev) alert_req = 1'b0;
    ack_prev = m_pulse && m_is_alert;
    if (raise && !alert_req && !ack_prev) begin
      alert_req  = 1'b1;
      alert_data = ad;
    end
    #1 check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_cycles(input int n, input bit done);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0, '0, done);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    req_valid = 1'b0;
    alert_req = 1'b0;
    fsm_done  = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_op = 2'd0; req_data = '0;
    alert_req = 1'b0; alert_data = '0; fsm_done = 1'b0;
    model_reset();
    #12 check_outputs();
    #1 rst = 1'b1;

    // Single INIT into an idle scheduler, done three cycles after the pulse.
    step(1'b1, OP_INIT, 16'h0010, 1'b0, '0, 1'b0);
    idle_cycles(4, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(2, 1'b0);

    // Fill the queue behind a START in WAIT, then push while it pops.
    step(1'b1, OP_START, 16'h0100, 1'b0, '0, 1'b0);
    idle_cycles(2, 1'b0);
    step(1'b1, OP_INIT,   16'h0201, 1'b0, '0, 1'b0);
    step(1'b1, OP_UPDATE, 16'h0202, 1'b0, '0, 1'b0);
    step(1'b1, OP_START,  16'h0203, 1'b0, '0, 1'b0);
    step(1'b1, OP_UPDATE, 16'h0204, 1'b0, '0, 1'b0);
    step(1'b1, OP_ALERT,  16'h0205, 1'b0, '0, 1'b0);
    step(1'b1, OP_INIT,   16'h0206, 1'b0, '0, 1'b1);
    step(1'b1, OP_START,  16'h0207, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle_cycles(2, 1'b0);
      idle_cycles(1, 1'b1);
    end
    idle_cycles(4, 1'b0);

    // Alert raised while a command waits, with two commands queued behind it.
    step(1'b1, OP_START, 16'h0300, 1'b0, '0, 1'b0);
    idle_cycles(2, 1'b0);
    step(1'b1, OP_UPDATE, 16'h0301, 1'b0, '0, 1'b0);
    step(1'b1, OP_INIT,   16'h0302, 1'b1, 16'hBEEF, 1'b0);
    idle_cycles(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycles(1, 1'b1);
      idle_cycles(3, 1'b0);
    end

    // Reset during WAIT with three commands queued.
    step(1'b1, OP_START,  16'h0400, 1'b0, '0, 1'b0);
    step(1'b1, OP_UPDATE, 16'h0401, 1'b0, '0, 1'b0);
    step(1'b1, OP_INIT,   16'h0402, 1'b0, '0, 1'b0);
    step(1'b1, OP_START,  16'h0403, 1'b0, '0, 1'b0);
    idle_cycles(1, 1'b0);
    mid_reset();
    idle_cycles(5, 1'b1);

    // Long stall without done: the watchdog, when built in, must release WAIT.
    step(1'b1, OP_UPDATE, 16'h0500, 1'b0, '0, 1'b0);
    step(1'b1, OP_START,  16'h0501, 1'b0, '0, 1'b0);
    idle_cycles(WD + 6, 1'b0);
    idle_cycles(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
           $urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 3) == 0);
    end
    idle_cycles(40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
